flash_read_sequencer: RTL and testbench

FLASH_READ_SEQUENCER -- requirements
Module: flash_read_sequencer

---
 rtl/flash_seq_pkg.sv | 26 ++
 rtl/flash_addr_gen.sv | 35 +++
 rtl/flash_read_sequencer.sv | 146 ++++++++++++++
 tb/tb_flash_read_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_seq_pkg.sv
// rtl/flash_seq_pkg.sv - shared types and helpers for the flash read sequencer
package flash_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  typedef logic [22:0] flash_addr_t;
  typedef logic [1:0]  byte_idx_t;

  localparam byte_idx_t LAST_BYTE = 2'd3;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input byte_idx_t lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_addr_gen.sv
// rtl/flash_addr_gen.sv - wrapping up/down word address counter for the audio region
module flash_addr_gen
  import flash_seq_pkg::*;
#(
  parameter flash_addr_t START_ADDR = 23'h000000,
  parameter flash_addr_t END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        dir,
  output flash_addr_t addr
);

  flash_addr_t addr_q;

  // load takes the region end when running backwards so playback starts at the tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= START_ADDR;
    end else if (load) begin
      addr_q <= dir ? END_ADDR : START_ADDR;
    end else if (step) begin
      if (dir) begin
        addr_q <= (addr_q == START_ADDR) ? END_ADDR : addr_q - 23'd1;
      end else begin
        addr_q <= (addr_q == END_ADDR) ? START_ADDR : addr_q + 23'd1;
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/flash_read_sequencer.sv
// rtl/flash_read_sequencer.sv - streams audio bytes from flash words over Avalon-MM reads
module flash_read_sequencer
  import flash_seq_pkg::*;
#(
  parameter flash_addr_t START_ADDR = 23'h000000,
  parameter flash_addr_t END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        reverse,
  input  logic        restart,
  input  logic        sample_tick,
  input  logic        flash_mem_waitrequest,
  input  logic        flash_mem_readdatavalid,
  input  logic [31:0] flash_mem_readdata,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [7:0]  audio_out,
  output logic        audio_valid,
  output logic        underrun
);

  seq_state_e  state, state_next;
  flash_addr_t gen_addr;
  logic        drain;

  logic        cur_valid, nxt_valid;
  logic [31:0] cur_word, nxt_word;
  byte_idx_t   byte_pos;

  logic        cur_valid_d, nxt_valid_d;
  logic [31:0] cur_word_d, nxt_word_d;
  byte_idx_t   byte_pos_d;

  logic        accepted, tick_take, consume, word_done, take_data;
  byte_idx_t   lane;

  assign flash_mem_read = (state == FETCH);
  assign accepted       = flash_mem_read && !flash_mem_waitrequest;
  assign tick_take      = sample_tick && enable && !restart;
  assign consume        = tick_take && cur_valid;
  assign word_done      = consume && (byte_pos == LAST_BYTE);
  assign take_data      = flash_mem_readdatavalid && (state == WAIT) && !drain && !restart;
  // byte_pos counts bytes taken from the word; direction only picks the lane
  assign lane           = reverse ? (LAST_BYTE - byte_pos) : byte_pos;

  flash_addr_gen #(
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (restart),
    .step  (accepted && !drain && !restart),
    .dir   (reverse),
    .addr  (gen_addr)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !drain && !(cur_valid && nxt_valid)) state_next = FETCH;
      FETCH:   if (accepted) state_next = (drain || restart) ? IDLE : WAIT;
      WAIT:    if (flash_mem_readdatavalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // a started handshake must finish, so restart cannot pull the FSM out of FETCH
    if (restart && (state != FETCH)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      drain             <= 1'b0;
      flash_mem_address <= START_ADDR;
    end else begin
      state <= state_next;
      if (restart) begin
        drain <= (state == FETCH) || (((state == WAIT) || drain) && !flash_mem_readdatavalid);
      end else if (drain && flash_mem_readdatavalid) begin
        drain <= 1'b0;
      end
      if (state != FETCH) flash_mem_address <= gen_addr;
    end
  end

  always_comb begin
    cur_valid_d = cur_valid;
    nxt_valid_d = nxt_valid;
    cur_word_d  = cur_word;
    nxt_word_d  = nxt_word;
    byte_pos_d  = byte_pos;
    if (consume) byte_pos_d = byte_pos + 2'd1;
    if (word_done) begin
      cur_valid_d = nxt_valid;
      cur_word_d  = nxt_word;
      nxt_valid_d = 1'b0;
      byte_pos_d  = '0;
    end
    // placement looks at cur after this cycle's consumption
    if (take_data) begin
      if (!cur_valid_d) begin
        cur_valid_d = 1'b1;
        cur_word_d  = flash_mem_readdata;
      end else begin
        nxt_valid_d = 1'b1;
        nxt_word_d  = flash_mem_readdata;
      end
    end
    if (restart) begin
      cur_valid_d = 1'b0;
      nxt_valid_d = 1'b0;
      byte_pos_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      cur_word  <= '0;
      nxt_word  <= '0;
      byte_pos  <= '0;
    end else begin
      cur_valid <= cur_valid_d;
      nxt_valid <= nxt_valid_d;
      cur_word  <= cur_word_d;
      nxt_word  <= nxt_word_d;
      byte_pos  <= byte_pos_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out   <= 8'h00;
      audio_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      audio_valid <= consume;
      underrun    <= tick_take && !cur_valid;
      if (consume) audio_out <= word_byte(cur_word, lane);
    end
  end

endmodule

// File: tb/tb_flash_read_sequencer.sv
// tb/tb_flash_read_sequencer.sv - directed bench for flash_read_sequencer with a flash slave model
module tb_flash_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, reverse, restart, sample_tick;
  logic        flash_mem_waitrequest, flash_mem_readdatavalid;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [7:0]  audio_out;
  logic        audio_valid, underrun;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem [0:3];
  logic [22:0] acc_addr [$];
  int          stall_cfg, stall_left, rdv_delay, rdv_cnt;
  bit          pend;
  logic [31:0] pend_data;

  always #5 clk = ~clk;

  flash_read_sequencer #(
    .START_ADDR (23'h000000),
    .END_ADDR   (23'h000003)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .reverse                 (reverse),
    .restart                 (restart),
    .sample_tick             (sample_tick),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .audio_out               (audio_out),
    .audio_valid             (audio_valid),
    .underrun                (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // flash slave: stalls each read stall_cfg cycles, returns data rdv_delay cycles after accept
  initial begin
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      flash_mem_readdatavalid = 1'b0;
      if (pend) begin
        if (rdv_cnt == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = pend_data;
          pend                    = 1'b0;
        end else begin
          rdv_cnt--;
        end
      end
      if (flash_mem_read && !reset) begin
        if (stall_left > 0) begin
          flash_mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          flash_mem_waitrequest = 1'b0;
          acc_addr.push_back(flash_mem_address);
          pend_data  = mem[flash_mem_address[1:0]];
          pend       = 1'b1;
          rdv_cnt    = rdv_delay;
          stall_left = stall_cfg;
        end
      end else begin
        flash_mem_waitrequest = 1'b0;
      end
    end
  end

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic wait_accepts(input string tag, input int n, input int budget);
    int k = 0;
    while (acc_addr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(acc_addr.size() >= n), 32'd1);
  endtask

  task automatic tick_expect(input string tag, input logic exp_v, input logic exp_u, input logic [7:0] exp_b);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    check({tag, "_valid"}, 32'(audio_valid), 32'(exp_v));
    check({tag, "_under"}, 32'(underrun), 32'(exp_u));
    check({tag, "_byte"}, 32'(audio_out), 32'(exp_b));
    @(negedge clk);
    check({tag, "_pulse"}, 32'({audio_valid, underrun}), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fwd_bytes [0:4];
    logic [7:0]  rev_bytes [0:11];
    logic [22:0] rev_addrs [0:4];
    int base, hi, stable;
    logic [22:0] a0;

    fwd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rev_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55};
    rev_addrs = '{23'd3, 23'd2, 23'd1, 23'd0, 23'd3};
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    mem[3] = 32'h44332211;
    stall_cfg = 0; stall_left = 0; rdv_delay = 2; rdv_cnt = 0; pend = 1'b0;
    reset = 1'b1; enable = 1'b0; reverse = 1'b0; restart = 1'b0; sample_tick = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_read", 32'(flash_mem_read), 32'd0);
    check("rst_addr", 32'(flash_mem_address), 32'd0);
    check("rst_audio", 32'(audio_out), 32'h00);
    check("rst_valid", 32'(audio_valid), 32'd0);
    check("rst_under", 32'(underrun), 32'd0);
    reset = 1'b0;
    enable = 1'b1;

    // forward playback
    wait_accepts("fwd_two_reads", 2, 50);
    check("fwd_addr0", 32'(acc_addr[0]), 32'd0);
    check("fwd_addr1", 32'(acc_addr[1]), 32'd1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) tick_expect($sformatf("fwd%0d", i), 1'b1, 1'b0, fwd_bytes[i]);
    wait_accepts("fwd_refill", 3, 50);
    check("fwd_addr2", 32'(acc_addr[2]), 32'd2);
    repeat (10) @(negedge clk);

    // reverse playback with wrap at START_ADDR
    reverse = 1'b1;
    base = acc_addr.size();
    pulse_restart();
    repeat (15) @(negedge clk);
    for (int i = 0; i < 12; i++) tick_expect($sformatf("rev%0d", i), 1'b1, 1'b0, rev_bytes[i]);
    wait_accepts("rev_reads", base + 5, 60);
    for (int i = 0; i < 5; i++) check($sformatf("rev_addr%0d", i), 32'(acc_addr[base + i]), 32'(rev_addrs[i]));
    repeat (15) @(negedge clk);

    // waitrequest stall
    reverse = 1'b0;
    stall_cfg = 5; stall_left = 5;
    base = acc_addr.size();
    pulse_restart();
    hi = 0;
    while (!flash_mem_read && hi < 20) begin
      @(negedge clk);
      hi++;
    end
    check("stall_read_seen", 32'(flash_mem_read), 32'd1);
    hi = 0; stable = 1; a0 = flash_mem_address;
    while (flash_mem_read && hi < 20) begin
      hi++;
      if (flash_mem_address !== a0) stable = 0;
      @(negedge clk);
    end
    check("stall_cycles", 32'(hi), 32'd6);
    check("stall_addr_stable", 32'(stable), 32'd1);
    check("stall_accepts", 32'(acc_addr.size() - base), 32'd1);
    check("stall_addr", 32'(acc_addr[base]), 32'd0);
    repeat (40) @(negedge clk);
    stall_cfg = 0; stall_left = 0;

    // underrun while the first word is still in flight
    rdv_delay = 20;
    pulse_restart();
    @(negedge clk);
    tick_expect("under", 1'b0, 1'b1, 8'h55);
    repeat (30) @(negedge clk);
    tick_expect("under_after", 1'b1, 1'b0, 8'h11);
    repeat (50) @(negedge clk);

    // restart while a read is outstanding discards its word
    rdv_delay = 10;
    mem[0] = 32'hDEADBEEF;
    base = acc_addr.size();
    pulse_restart();
    wait_accepts("drain_first_read", base + 1, 20);
    repeat (3) @(negedge clk);
    mem[0] = 32'h44332211;
    base = acc_addr.size();
    pulse_restart();
    wait_accepts("drain_next_read", base + 1, 40);
    check("drain_addr", 32'(acc_addr[base]), 32'd0);
    repeat (20) @(negedge clk);
    tick_expect("drain_first", 1'b1, 1'b0, 8'h11);
    repeat (40) @(negedge clk);

    // reset in the middle of a stalled read
    rdv_delay = 2;
    stall_cfg = 8; stall_left = 8;
    reverse = 1'b1;
    pulse_restart();
    hi = 0;
    while (!flash_mem_read && hi < 20) begin
      @(negedge clk);
      hi++;
    end
    check("mr_addr_before", 32'(flash_mem_address), 32'd3);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mr_read_drop", 32'(flash_mem_read), 32'd0);
    check("mr_addr_reset", 32'(flash_mem_address), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reverse = 1'b0;
    pend = 1'b0; stall_cfg = 0; stall_left = 0;
    @(negedge clk);
    base = acc_addr.size();
    reset = 1'b0;
    wait_accepts("mr_read_after", base + 1, 20);
    check("mr_first_addr", 32'(acc_addr[base]), 32'd0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
